counter_seq_ctrl: RTL
=====================

// Module: counter_seq_ctrl
// PURPOSE
//  Command sequencer that drives a loadable up-counter (LOAD/COUNT/COUNT_IN in, COUNT_OUT back).
//  On START it loads START_VAL into the counter and issues COUNT pulses until COUNT_OUT reaches END_VAL.
//  Checks the counter's response every cycle and flags the first mismatch.
//  Sits between a host/control block and the counter datapath.
// PARAMETERS
//  WIDTH  8  data width of START_VAL, END_VAL, COUNT_IN, COUNT_OUT, STEPS, ERR_VAL
// PORTS
//  CLK        in   1      system clock, rising edge
//  RST_N      in   1      synchronous active-low reset
//  START      in   1      begin a sequence; sampled only in IDLE or ERR
//  ABORT      in   1      cancel the active sequence
//  START_VAL  in   WIDTH  value to load; latched when START is accepted
//  END_VAL    in   WIDTH  terminal value; latched when START is accepted
//  COUNT_OUT  in   WIDTH  counter output (feedback)
//  LOAD       out  1      counter load strobe
//  COUNT      out  1      counter increment enable
//  COUNT_IN   out  WIDTH  counter load data (latched START_VAL)
//  BUSY       out  1      sequence in progress (LOAD or RUN)
//  DONE       out  1      one-cycle pulse on successful completion
//  ERR        out  1      counter response mismatch; held until restart or reset
//  STEPS      out  WIDTH  COUNT pulses issued in the current or last sequence
//  ERR_VAL    out  WIDTH  COUNT_OUT captured at the mismatch
// BEHAVIOUR
//  Reset behaviour:
//  - RST_N=0 at an edge forces state IDLE and clears sv, ev, exp, STEPS and ERR_VAL to 0.
//  - With state IDLE and COUNT_OUT irrelevant, LOAD=COUNT=BUSY=DONE=ERR=0 and COUNT_IN=0.
//  Counter model:
//  - Counter registers on CLK; LOAD has priority over COUNT.
//  - COUNT_OUT reflects a load or an increment one cycle later and wraps mod 2^WIDTH.
//  - This block never asserts LOAD and COUNT together.
//  Internal registers: state; sv and ev (latched START_VAL/END_VAL); exp (expected COUNT_OUT); STEPS; ERR_VAL.
//  States:
//  - IDLE: START=1 -> sv<=START_VAL, ev<=END_VAL, STEPS<=0, next LOAD.
//  - LOAD: LOAD=1 and COUNT_IN=sv for exactly one cycle. exp<=sv, next RUN.
//  - RUN, evaluated each cycle in this priority order:
//    - a) COUNT_OUT!=exp -> ERR_VAL<=COUNT_OUT, next ERR, COUNT=0.
//    - b) COUNT_OUT==ev -> next DONE, COUNT=0.
//    - c) otherwise COUNT=1, exp<=exp+1 (wraps), STEPS<=STEPS+1, stay in RUN.
//  - DONE: DONE=1 for one cycle, next IDLE. A START in this cycle is ignored.
//  - ERR: ERR=1 and stays in ERR until START=1, which takes the IDLE path and clears ERR.
//  Output decode:
//  - COUNT is combinational: COUNT = (state==RUN) && (COUNT_OUT==exp) && (COUNT_OUT!=ev).
//  - All other outputs are decoded from registers only.
//  - COUNT_IN is driven from sv in every state, so it holds its value after LOAD.
//  Sequence length and latency:
//  - Steps N = (ev - sv) mod 2^WIDTH. sv==ev gives N=0, so no COUNT pulses are issued.
//  - With START accepted in cycle 0: LOAD is high in cycle 1 and the first RUN cycle is 2.
//  - COUNT is high in cycles 2..N+1 and DONE is high in cycle N+3.
//  - Wrap case: ev<sv counts through 2^WIDTH-1 -> 0 (e.g. 0xFE -> 0x01 is N=3).
//  ABORT:
//  - ABORT=1 in LOAD or RUN -> next IDLE. COUNT is forced to 0 in that same cycle.
//  - No DONE and no ERR are raised. STEPS holds its value.
//  - ABORT has priority over the mismatch and done checks.
//  - ABORT is ignored in IDLE, DONE and ERR.
//  START:
//  - START while BUSY is ignored.
//  - START and ABORT asserted together in IDLE or ERR -> START wins.
//  Reset mid-sequence: the next cycle is IDLE with all outputs at their reset values.
// TESTING
//  1. sv=3, ev=6, ideal counter -> LOAD in cycle 1 with COUNT_IN=3.
//     COUNT high in cycles 2-4, DONE pulse in cycle 6, STEPS=3, ERR=0.
//  2. sv=ev=0x10 -> LOAD in cycle 1, no COUNT pulses, DONE in cycle 3, STEPS=0.
//  3. sv=0xFE, ev=0x01 -> COUNT_OUT sequence FE,FF,00,01, STEPS=3, DONE in cycle 6.
//  4. Counter stuck at 0x05 after load of 5 (ev=9) -> ERR in cycle 4, ERR_VAL=0x05.
//     A following START clears ERR and restarts the sequence.
//  5. ABORT in cycle 3 of a sv=0, ev=0x20 run -> IDLE in cycle 4, COUNT=0 in cycle 3.
//     No DONE, STEPS=1, and START in cycle 2 is ignored.
//  6. RST_N=0 mid-RUN -> all outputs 0 next cycle.
//     Sequence restarts cleanly on START once RST_N=1.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl
//   Command sequencer for a loadable up-counter. On i_start it latches the
//   start/end values, loads the counter, then issues increment pulses until
//   the counter reports the end value. Every RUN cycle the counter output is
//   compared against the value this block expects. The first disagreement
//   parks the block in ERR and captures the offending value.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst_n       synchronous active-low reset
//   i_start       begin a sequence (accepted in IDLE or ERR only)
//   i_abort       cancel an active sequence (LOAD or RUN only)
//   i_start_val   value loaded into the counter (latched on accepted start)
//   i_end_val     terminal counter value (latched on accepted start)
//   i_count_out   counter output fed back from the datapath
//   o_load        counter load strobe
//   o_count       counter increment enable (combinational)
//   o_count_in    counter load data; always the latched start value
//   o_busy        sequence in progress (LOAD or RUN)
//   o_done        one-cycle pulse on successful completion
//   o_err         counter mismatch seen; held until restart or reset
//   o_steps       increment pulses issued in the current/last sequence
//   o_err_val     counter output captured at the mismatch
// -----------------------------------------------------------------------------
module counter_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_start_val,
  input  logic [WIDTH-1:0] i_end_val,
  input  logic [WIDTH-1:0] i_count_out,
  output logic             o_load,
  output logic             o_count,
  output logic [WIDTH-1:0] o_count_in,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [WIDTH-1:0] o_steps,
  output logic [WIDTH-1:0] o_err_val
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sv,      w_sv_nxt;
  logic [WIDTH-1:0] r_ev,      w_ev_nxt;
  logic [WIDTH-1:0] r_exp,     w_exp_nxt;
  logic [WIDTH-1:0] r_steps,   w_steps_nxt;
  logic [WIDTH-1:0] r_err_val, w_err_val_nxt;
  logic             w_count;
  logic             w_match;
  logic             w_at_end;

  // Counter agrees with our model / counter has reached the terminal value.
  assign w_match  = (i_count_out == r_exp);
  assign w_at_end = (i_count_out == r_ev);

  // ---------------------------------------------------------------------------
  // Next-state and increment decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_sv_nxt      = r_sv;
    w_ev_nxt      = r_ev;
    w_exp_nxt     = r_exp;
    w_steps_nxt   = r_steps;
    w_err_val_nxt = r_err_val;
    w_count       = 1'b0;

    unique case (r_state)
      // ERR restarts through the same path as IDLE; leaving ERR is what
      // clears the error flag since o_err is a pure state decode.
      S_IDLE, S_ERR: begin
        if (i_start) begin
          w_sv_nxt    = i_start_val;
          w_ev_nxt    = i_end_val;
          w_steps_nxt = '0;
          w_state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          // Counter shows the loaded value on the first RUN cycle.
          w_exp_nxt   = r_sv;
          w_state_nxt = S_RUN;
        end
      end

      // Priority: abort, then mismatch, then terminal value, then increment.
      S_RUN: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (!w_match) begin
          w_err_val_nxt = i_count_out;
          w_state_nxt   = S_ERR;
        end else if (w_at_end) begin
          w_state_nxt = S_DONE;
        end else begin
          w_count     = 1'b1;
          w_exp_nxt   = r_exp + 1'b1;
          w_steps_nxt = r_steps + 1'b1;
        end
      end

      // Start during the DONE pulse is deliberately dropped.
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_sv      <= '0;
      r_ev      <= '0;
      r_exp     <= '0;
      r_steps   <= '0;
      r_err_val <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sv      <= w_sv_nxt;
      r_ev      <= w_ev_nxt;
      r_exp     <= w_exp_nxt;
      r_steps   <= w_steps_nxt;
      r_err_val <= w_err_val_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: only o_count looks at live inputs; the rest are register decodes.
  // ---------------------------------------------------------------------------
  assign o_load     = (r_state == S_LOAD);
  assign o_count    = w_count;
  assign o_count_in = r_sv;
  assign o_busy     = (r_state == S_LOAD) || (r_state == S_RUN);
  assign o_done     = (r_state == S_DONE);
  assign o_err      = (r_state == S_ERR);
  assign o_steps    = r_steps;
  assign o_err_val  = r_err_val;

endmodule
